// File: rtl/int2float_pkg.sv
// Shared definitions for the integer-to-float arbiter slice.
//   INT_W/FLT_W/EXP_W/MAN_W : operand and result widths
//   flt_t                   : packed {exp, man} result
//   conv_int2float          : 11-bit unsigned integer -> 7-bit float, truncating
package int2float_pkg;

    localparam int unsigned INT_W = 11;
    localparam int unsigned FLT_W = 7;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned MAN_W = 4;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } flt_t;

    // Values below 16 are exact with exp = 0. Otherwise the mantissa is the four bits
    // headed by the MSB; the ascending scan lets the highest set bit win.
    function automatic flt_t conv_int2float(input logic [INT_W-1:0] x);
        flt_t r;
        r.exp = '0;
        r.man = x[MAN_W-1:0];
        for (int m = MAN_W; m < INT_W; m++) begin
            if (x[m]) begin
                r.exp = EXP_W'(m - 3);
                r.man = MAN_W'(x >> (m - 3));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/int2float_conv.sv
// Purely combinational 11-bit unsigned integer to 7-bit float converter.
//   data_i : unsigned integer operand
//   flt_o  : {exp[2:0], man[3:0]}, value = man << exp (low bits truncated)
module int2float_conv
    import int2float_pkg::*;
(
    input  logic [INT_W-1:0] data_i,
    output flt_t             flt_o
);

    assign flt_o = conv_int2float(data_i);

endmodule

// File: rtl/int2float_arbiter.sv
// Shares one int-to-float converter among NREQ requesters with round-robin arbitration.
// Two-stage pipeline (operand register s1, result register s2), one conversion per cycle.
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_data   : packed operands, requester i at [11*i+10:11*i]
//   req_ready  : per-requester accept, one-hot or zero
//   out_valid  : result valid
//   out_data   : result {exp[2:0], man[3:0]}
//   out_id     : id of the requester that supplied the result
//   out_ready  : downstream accept
module int2float_arbiter
    import int2float_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*INT_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [FLT_W-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready
);

    logic             s1_valid_q;
    logic [INT_W-1:0] s1_data_q;
    logic [IDW-1:0]   s1_id_q;
    logic             s2_valid_q;
    flt_t             s2_flt_q;
    logic [IDW-1:0]   s2_id_q;
    logic [IDW-1:0]   lastg_q;

    logic             s2_can_load;
    logic             s1_can_accept;
    logic             any_valid;
    logic             accepted;
    logic [IDW-1:0]   grant;
    logic [INT_W-1:0] grant_data;
    flt_t             conv_flt;

    // Walk from the farthest candidate (lastg+NREQ) down to the nearest (lastg+1) so the
    // nearest valid requester after the last grant is the one left in grant.
    always_comb begin
        logic [IDW-1:0] idx;
        idx       = '0;
        grant     = '0;
        any_valid = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDW'((int'(lastg_q) + i) % NREQ);
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    assign s2_can_load   = ~s2_valid_q | out_ready;
    assign s1_can_accept = ~s1_valid_q | s2_can_load;
    assign accepted      = any_valid & s1_can_accept & ~rst;
    assign grant_data    = req_data[grant*INT_W +: INT_W];

    always_comb begin
        req_ready = '0;
        if (accepted) begin
            req_ready[grant] = 1'b1;
        end
    end

    int2float_conv u_conv (
        .data_i (s1_data_q),
        .flt_o  (conv_flt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_flt_q   <= '0;
            s2_id_q    <= '0;
            lastg_q    <= IDW'(NREQ - 1);
        end else begin
            // Payload only moves with a valid token so a stalled result stays put.
            if (s2_can_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_flt_q <= conv_flt;
                    s2_id_q  <= s1_id_q;
                end
            end
            if (s1_can_accept) begin
                s1_valid_q <= accepted;
                if (accepted) begin
                    s1_data_q <= grant_data;
                    s1_id_q   <= grant;
                end
            end
            if (accepted) begin
                lastg_q <= grant;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_flt_q;
    assign out_id    = s2_id_q;

endmodule

// File: tb/tb_int2float_arbiter.sv
// Self-checking bench for int2float_arbiter: directed scenarios plus a random run, with a
// queue scoreboard filled at each acceptance and drained at each result transfer.
module tb_int2float_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned W    = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [6:0]        out_data;
    logic [IDW-1:0]    out_id;
    logic              out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IDW+6:0]  sbq[$];
    logic [NREQ-1:0] acc_mask = '0;
    logic [NREQ-1:0] prev_pend = '0;
    logic [W-1:0]    prev_data [NREQ];
    logic            prev_stall = 1'b0;
    logic [6:0]      prev_out_data = '0;
    logic [IDW-1:0]  prev_out_id = '0;
    int              waits [NREQ];

    int2float_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Reference conversion: shift right until the value fits in four bits.
    function automatic logic [6:0] model_conv(input logic [W-1:0] x);
        logic [W-1:0] y;
        int           e;
        y = x;
        e = 0;
        while (y > 11'd15) begin
            y = y >> 1;
            e++;
        end
        return {3'(e), y[3:0]};
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] v);
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = v;
    endtask

    // One clock: sample at the falling edge, service the scoreboard, return 1ns after the
    // rising edge so the caller can drive new inputs.
    task automatic tick();
        logic [IDW+6:0] e;
        @(negedge clk);
        acc_mask = '0;
        if (rst) begin
            sbq.delete();
            prev_pend  = '0;
            prev_stall = 1'b0;
            for (int i = 0; i < NREQ; i++) waits[i] = 0;
        end else begin
            n_checks++;
            if ($countones(req_ready) > 1) begin
                n_fail++;
                $display("FAIL ready_onehot: req_ready=%b, required at most one bit set",
                         req_ready);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (prev_pend[i]) begin
                    n_checks++;
                    if (!req_valid[i] || req_data[i*W +: W] !== prev_data[i]) begin
                        n_fail++;
                        $display("FAIL req_hold[%0d]: valid=%b data=%0d, required 1/%0d",
                                 i, req_valid[i], req_data[i*W +: W], prev_data[i]);
                    end
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_out_data || out_id !== prev_out_id)
                begin
                    n_fail++;
                    $display("FAIL stall_stable: valid=%b data=%h id=%0d, required 1 %h %0d",
                             out_valid, out_data, out_id, prev_out_data, prev_out_id);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: id=%0d data=%h, required no result",
                             out_id, out_data);
                end else begin
                    e = sbq.pop_front();
                    if ({out_id, out_data} !== e) begin
                        n_fail++;
                        $display("FAIL result: id=%0d data=%h, required id=%0d data=%h",
                                 out_id, out_data, e[IDW+6:7], e[6:0]);
                    end
                end
            end
            acc_mask = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) begin
                    sbq.push_back({IDW'(i), model_conv(req_data[i*W +: W])});
                    n_checks++;
                    if (waits[i] > int'(NREQ) - 1) begin
                        n_fail++;
                        $display("FAIL fairness[%0d]: waited %0d acceptances, required <= %0d",
                                 i, waits[i], NREQ - 1);
                    end
                    waits[i] = 0;
                end else if (req_valid[i] && acc_mask != '0) begin
                    waits[i]++;
                end else if (!req_valid[i]) begin
                    waits[i] = 0;
                end
                prev_data[i] = req_data[i*W +: W];
            end
            prev_pend     = req_valid & ~acc_mask;
            prev_stall    = out_valid & ~out_ready;
            prev_out_data = out_data;
            prev_out_id   = out_id;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Hold each pending request until it is accepted, then drain the pipeline.
    task automatic retire_all();
        int budget;
        out_ready = 1'b1;
        budget    = 0;
        while (req_valid != '0 && budget < 8 * NREQ) begin
            tick();
            req_valid &= ~acc_mask;
            budget++;
        end
        n_checks++;
        if (req_valid != '0) begin
            n_fail++;
            $display("FAIL retire_timeout: req_valid=%b, required 0000", req_valid);
        end
        req_valid = '0;
        budget    = 0;
        while (sbq.size() != 0 && budget < 10) begin
            tick();
            budget++;
        end
        tick();
        tick();
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 7'h00 || out_id !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h id=%0d, required 0 00 0",
                     out_valid, out_data, out_id);
        end
        for (int i = 0; i < NREQ; i++) set_req(i, W'(100 + i));
        #1;
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b, required 0000", req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b, required 0001", req_ready);
        end
        out_ready = 1'b1;
        tick();
        retire_all();
    endtask

    task automatic test_conversion();
        logic [W-1:0] vals [5];
        logic [6:0]   exps [5];
        vals = '{11'd0, 11'd15, 11'd16, 11'd100, 11'd2047};
        exps = '{7'h00, 7'h0F, 7'h18, 7'h3C, 7'h7F};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(0, vals[k]);
            tick();
            req_valid = '0;
            n_checks++;
            if (acc_mask !== 4'b0001 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL conv_accept[%0d]: acc=%b out_valid=%b, required 0001 0",
                         vals[k], acc_mask, out_valid);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exps[k] || out_id !== 2'd0) begin
                n_fail++;
                $display("FAIL conv[%0d]: valid=%b data=%h id=%0d, required 1 %h 0",
                         vals[k], out_valid, out_data, out_id, exps[k]);
            end
            tick();
        end
        retire_all();
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_mask;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, W'(i * 300 + 7));
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_mask = NREQ'(1) << (k % NREQ);
            n_checks++;
            if (acc_mask !== exp_mask) begin
                n_fail++;
                $display("FAIL fairness_order[%0d]: acc=%b, required %b", k, acc_mask, exp_mask);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) set_req(i, W'($urandom_range(0, 2047)));
            end
        end
        retire_all();
    endtask

    task automatic test_back_to_back();
        int n_acc;
        logic [NREQ-1:0] order [2];
        do_reset();
        out_ready = 1'b0;
        n_acc     = 0;
        order     = '{default: '0};
        for (int i = 0; i < NREQ; i++) set_req(i, W'(i * 500 + 33));
        for (int k = 0; k < 10; k++) begin
            tick();
            if (acc_mask != '0) begin
                if (n_acc < 2) order[n_acc] = acc_mask;
                n_acc++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) set_req(i, W'($urandom_range(0, 2047)));
            end
        end
        n_checks++;
        if (n_acc != 2 || order[0] !== 4'b0001 || order[1] !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_accepts: %0d (%b,%b), required 2 (0001,0010)",
                     n_acc, order[0], order[1]);
        end
        n_checks++;
        if (req_ready !== '0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_full: req_ready=%b out_valid=%b, required 0000 1",
                     req_ready, out_valid);
        end
        retire_all();
    endtask

    task automatic test_sparse();
        logic [NREQ-1:0] seq [3];
        seq = '{4'b1000, 4'b0010, 4'b1000};
        do_reset();
        out_ready = 1'b1;
        set_req(1, 11'd40);
        tick();
        n_checks++;
        if (acc_mask !== 4'b0010) begin
            n_fail++;
            $display("FAIL sparse_setup: acc=%b, required 0010", acc_mask);
        end
        set_req(1, 11'd41);
        set_req(3, 11'd1500);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (acc_mask !== seq[k]) begin
                n_fail++;
                $display("FAIL sparse[%0d]: acc=%b, required %b", k, acc_mask, seq[k]);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) set_req(i, W'($urandom_range(0, 2047)));
            end
        end
        retire_all();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b0;
        set_req(0, 11'd900);
        set_req(2, 11'd901);
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) set_req(i, W'(200 + k));
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL midflight_full: out_valid=%b req_ready=%b, required 1 0000",
                     out_valid, req_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 7'h00) begin
            n_fail++;
            $display("FAIL midflight_flush: out_valid=%b data=%h, required 0 00",
                     out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (acc_mask !== 4'b0001) begin
            n_fail++;
            $display("FAIL midflight_grant: acc=%b, required 0001", acc_mask);
        end
        req_valid &= ~acc_mask;
        retire_all();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            req_valid &= ~acc_mask;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 9) < 5) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, W'($urandom_range(0, 15)));
                    else set_req(i, W'($urandom_range(0, 2047)));
                end
            end
        end
        retire_all();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            prev_data[i] = '0;
            waits[i]     = 0;
        end
        test_reset();
        test_conversion();
        test_fairness();
        test_back_to_back();
        test_sparse();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
